blake2_digest_serializer: RTL and testbench

//  Output-side counterpart of the BLAKE2 input controller. The controller packs BUS_WIDTH input words into

---
 rtl/blake2_digest_serializer.sv | 138 +++++++++++++
 tb/tb_blake2_digest_serializer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/blake2_digest_serializer.sv
// BLAKE2 digest serializer: captures a core digest and streams it out as
// BUS_WIDTH words over valid/ready, with per-byte keep and a last marker.

// One output byte lane: passes its byte through when it lies inside the
// remaining digest length, otherwise forces zero and clears its keep bit.
module blake2_out_lane #(
  parameter int LANE  = 0,
  parameter int LEN_W = 7
) (
  input  logic             active,
  input  logic [LEN_W-1:0] rem,
  input  logic [7:0]       byte_in,
  output logic [7:0]       byte_out,
  output logic             keep
);
  assign keep     = active && (rem > LEN_W'(LANE));
  assign byte_out = keep ? byte_in : 8'h00;
endmodule

module blake2_digest_serializer #(
  parameter int BUS_WIDTH    = 64,
  parameter int DIGEST_WIDTH = 512
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    digest_valid,
  input  logic [DIGEST_WIDTH-1:0] digest,
  input  logic [6:0]              digest_len,
  input  logic                    flush,
  output logic [BUS_WIDTH-1:0]    dout,
  output logic [BUS_WIDTH/8-1:0]  dout_keep,
  output logic                    valid_out,
  input  logic                    ready_in,
  output logic                    last_out,
  output logic                    digest_accept,
  output logic                    overflow
);
  localparam int BUS_BYTES = BUS_WIDTH / 8;
  localparam int MAX_BYTES = DIGEST_WIDTH / 8;
  localparam int NWORDS    = DIGEST_WIDTH / BUS_WIDTH;
  localparam int IDX_W     = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int LEN_W     = $clog2(MAX_BYTES + 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                        state_q, state_d;
  logic [IDX_W-1:0]              idx_q, idx_d, last_idx_q;
  logic [LEN_W-1:0]              len_q, len_cap, rem;
  logic [DIGEST_WIDTH-1:0]       digest_q;
  logic                          overflow_q;
  logic                          cap, send, last;
  logic [NWORDS-1:0][BUS_WIDTH-1:0] words;
  logic [BUS_WIDTH-1:0]          cur_word;

  // Zero or oversize lengths mean "full digest".
  assign len_cap = (digest_len == '0 || int'(digest_len) > MAX_BYTES)
                   ? LEN_W'(MAX_BYTES) : LEN_W'(digest_len);

  assign send = (state_q == SEND);
  assign last = send && (idx_q == last_idx_q);

  // Next-state, index advance, capture strobe and back-pressure.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    cap           = 1'b0;
    digest_accept = !send || (ready_in && last);
    if (flush) begin
      state_d = IDLE;
      idx_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (digest_valid) begin
            cap     = 1'b1;
            state_d = SEND;
            idx_d   = '0;
          end
        end
        SEND: begin
          if (ready_in) begin
            if (last) begin
              idx_d = '0;
              if (digest_valid) cap = 1'b1;   // back-to-back, stay in SEND
              else              state_d = IDLE;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end
        end
        default: begin
          state_d = IDLE;
          idx_d   = '0;
        end
      endcase
    end
  end

  // State, index and capture registers; overflow is sticky until reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      last_idx_q <= '0;
      len_q      <= '0;
      digest_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (cap) begin
        digest_q   <= digest;
        len_q      <= len_cap;
        last_idx_q <= IDX_W'((int'(len_cap) + BUS_BYTES - 1) / BUS_BYTES - 1);
      end
      if (digest_valid && !digest_accept && !flush) overflow_q <= 1'b1;
    end
  end

  // Word select and per-lane masking, decoded from registered state only.
  assign words    = digest_q;
  assign cur_word = words[idx_q];
  assign rem      = len_q - LEN_W'(idx_q) * LEN_W'(BUS_BYTES);

  for (genvar i = 0; i < BUS_BYTES; i++) begin : g_lane
    blake2_out_lane #(.LANE(i), .LEN_W(LEN_W)) u_lane (
      .active   (send),
      .rem      (rem),
      .byte_in  (cur_word[8*i +: 8]),
      .byte_out (dout[8*i +: 8]),
      .keep     (dout_keep[i])
    );
  end

  assign valid_out = send;
  assign last_out  = last;
  assign overflow  = overflow_q;
endmodule

// File: tb/tb_blake2_digest_serializer.sv
// Self-checking bench: length table plus hand-written stall, back-to-back,
// overflow, flush and async-reset sequences, checked through a scoreboard.
module tb_blake2_digest_serializer;
  localparam int BW = 64;
  localparam int DW = 512;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          digest_valid = 1'b0;
  logic [DW-1:0] digest = '0;
  logic [6:0]    digest_len = '0;
  logic          flush = 1'b0;
  logic          ready_in = 1'b0;
  logic [BW-1:0] dout;
  logic [7:0]    dout_keep;
  logic          valid_out, last_out, digest_accept, overflow;

  blake2_digest_serializer #(.BUS_WIDTH(BW), .DIGEST_WIDTH(DW)) dut (
    .clk(clk), .reset_n(reset_n), .digest_valid(digest_valid), .digest(digest),
    .digest_len(digest_len), .flush(flush), .dout(dout), .dout_keep(dout_keep),
    .valid_out(valid_out), .ready_in(ready_in), .last_out(last_out),
    .digest_accept(digest_accept), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct { logic [63:0] d; logic [7:0] k; logic l; } exp_t;
  typedef struct { int len; int nw; logic [63:0] last_word; logic [7:0] last_keep; } vec_t;

  exp_t          q[$];
  int            total = 0, bad = 0;
  int            word_cnt = 0, last_cnt = 0;
  logic [63:0]   last_d;
  logic [7:0]    last_k;
  logic [DW-1:0] d0, d1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Reference model of one output word.
  function automatic exp_t model_word(input logic [DW-1:0] d, input int len, input int w);
    exp_t e;
    int   eff, nw, p;
    eff = (len == 0 || len > 64) ? 64 : len;
    nw  = (eff + 7) / 8;
    e.d = '0;
    e.k = '0;
    for (int b = 0; b < 8; b++) begin
      p = w * 8 + b;
      if (p < eff) begin
        e.d[8*b +: 8] = d[8*p +: 8];
        e.k[b] = 1'b1;
      end
    end
    e.l = (w == nw - 1);
    return e;
  endfunction

  // Monitor: pops the scoreboard on each handshake and checks stall stability.
  logic        prev_v = 1'b0, prev_r = 1'b0, prev_f = 1'b0, prev_l = 1'b0;
  logic [63:0] prev_d = '0;
  logic [7:0]  prev_k = '0;
  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      prev_v = 1'b0;
    end else begin
      if (prev_v && !prev_r && !prev_f) begin
        chk("stall_valid", valid_out, 1);
        chk("stall_dout", dout, prev_d);
        chk("stall_keep", dout_keep, prev_k);
        chk("stall_last", last_out, prev_l);
      end
      if (valid_out && ready_in) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_word: got %h want none", dout);
        end else begin
          e = q.pop_front();
          chk("sb_dout", dout, e.d);
          chk("sb_keep", dout_keep, e.k);
          chk("sb_last", last_out, e.l);
          word_cnt++;
          if (last_out) begin
            last_cnt++;
            last_d = dout;
            last_k = dout_keep;
          end
        end
      end
      prev_v = valid_out; prev_r = ready_in; prev_f = flush;
      prev_d = dout; prev_k = dout_keep; prev_l = last_out;
    end
  end

  // Pulse digest_valid for one cycle; push expected words if it should be taken.
  task automatic send(input logic [DW-1:0] d, input int len, input bit exp_acc);
    int eff, nw;
    digest       = d;
    digest_len   = 7'(len);
    digest_valid = 1'b1;
    chk("accept", digest_accept, exp_acc);
    if (exp_acc) begin
      eff = (len == 0 || len > 64) ? 64 : len;
      nw  = (eff + 7) / 8;
      for (int w = 0; w < nw; w++) q.push_back(model_word(d, len, w));
    end
    @(posedge clk); #1;
    digest_valid = 1'b0;
    chk("lat_valid", valid_out, 1);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d left want 0", q.size());
      q.delete();
    end
    chk("idle_after", valid_out, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    bit   pat[4];
    int   c;
    exp_t e;
    vecs[0] = '{64,  8, 64'h3F3E3D3C3B3A3938, 8'hFF};
    vecs[1] = '{20,  3, 64'h0000000013121110, 8'h0F};
    vecs[2] = '{0,   8, 64'h3F3E3D3C3B3A3938, 8'hFF};
    vecs[3] = '{100, 8, 64'h3F3E3D3C3B3A3938, 8'hFF};
    vecs[4] = '{1,   1, 64'h0000000000000000, 8'h01};
    vecs[5] = '{8,   1, 64'h0706050403020100, 8'hFF};
    vecs[6] = '{9,   2, 64'h0000000000000008, 8'h01};
    vecs[7] = '{50,  7, 64'h0000000000003130, 8'h03};
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 64; i++) begin
      d0[8*i +: 8] = 8'(i);
      d1[8*i +: 8] = 8'(i) ^ 8'hA5;
    end

    // reset state
    repeat (2) @(posedge clk); #1;
    chk("rst_dout", dout, 0);
    chk("rst_keep", dout_keep, 0);
    chk("rst_valid", valid_out, 0);
    chk("rst_last", last_out, 0);
    chk("rst_accept", digest_accept, 1);
    chk("rst_ovf", overflow, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    ready_in = 1'b1;

    // length table, full rate
    for (int i = 0; i < 8; i++) begin
      word_cnt = 0; last_cnt = 0;
      send(d0, vecs[i].len, 1);
      drain();
      chk("vec_nwords", word_cnt, vecs[i].nw);
      chk("vec_lastcnt", last_cnt, 1);
      chk("vec_lastword", last_d, vecs[i].last_word);
      chk("vec_lastkeep", last_k, vecs[i].last_keep);
    end

    // stall pattern 1,0,0,1
    word_cnt = 0;
    send(d1, 64, 1);
    c = 0;
    while (q.size() > 0 && c < 100) begin
      ready_in = pat[c % 4];
      @(posedge clk); #1;
      c++;
    end
    chk("stall_words", word_cnt, 8);
    chk("stall_idle", valid_out, 0);
    ready_in = 1'b1;

    // back-to-back digest in the last-word handshake cycle
    word_cnt = 0;
    send(d0, 16, 1);
    @(posedge clk); #1;
    send(d1, 24, 1);
    e = model_word(d1, 24, 0);
    chk("b2b_word0", dout, e.d);
    chk("b2b_ovf", overflow, 0);
    drain();
    chk("b2b_words", word_cnt, 5);

    // digest mid-stream is dropped and sets overflow
    word_cnt = 0;
    send(d0, 64, 1);
    repeat (2) begin @(posedge clk); #1; end
    send(d1, 64, 0);
    chk("mid_ovf", overflow, 1);
    drain();
    chk("mid_words", word_cnt, 8);

    // flush while word 3 is presented, with a digest_valid in the same cycle
    send(d0, 64, 1);
    repeat (3) begin @(posedge clk); #1; end
    chk("flush_at_w3", dout, 64'h1F1E1D1C1B1A1918);
    ready_in = 1'b0; flush = 1'b1; digest_valid = 1'b1; digest = d1;
    @(posedge clk); #1;
    flush = 1'b0; digest_valid = 1'b0;
    q.delete();
    chk("flush_valid", valid_out, 0);
    chk("flush_accept", digest_accept, 1);
    chk("flush_keeps_ovf", overflow, 1);
    @(posedge clk); #1;
    chk("flush_stay_idle", valid_out, 0);
    ready_in = 1'b1;

    // asynchronous reset mid-stream
    send(d0, 64, 1);
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    q.delete();
    chk("arst_dout", dout, 0);
    chk("arst_keep", dout_keep, 0);
    chk("arst_valid", valid_out, 0);
    chk("arst_last", last_out, 0);
    chk("arst_accept", digest_accept, 1);
    chk("arst_ovf", overflow, 0);
    @(posedge clk); #3;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // flush with digest_valid in IDLE: dropped, no overflow
    flush = 1'b1; digest_valid = 1'b1; digest = d0; digest_len = 7'd64;
    @(posedge clk); #1;
    flush = 1'b0; digest_valid = 1'b0;
    chk("flush_idle_valid", valid_out, 0);
    chk("flush_idle_ovf", overflow, 0);

    // normal operation after reset
    word_cnt = 0;
    send(d1, 24, 1);
    drain();
    chk("post_words", word_cnt, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
